// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning front end:
// per-channel debounce state encoding and the fixed button index map.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } btn_state_e;

  localparam int unsigned BTN_CENTER = 0;
  localparam int unsigned BTN_TOP    = 1;
  localparam int unsigned BTN_BOTTOM = 2;
  localparam int unsigned BTN_LEFT   = 3;
  localparam int unsigned BTN_RIGHT  = 4;

endpackage

// File: rtl/btn_debounce_ch.sv
// Single button channel: 2-flop synchroniser, debounce FSM with saturating
// counter, registered one-cycle press pulse and debounced level.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_raw,
  output logic btn_pulse,
  output logic btn_level
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  btn_state_e       state_q;
  btn_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pulse_q;
  logic             pulse_d;
  logic             level_q;
  logic             level_d;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  // Next state: a level change is accepted only after an unbroken run of
  // opposite samples; the counter holds at its terminal value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s2) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_d = HELD;
        end else if (cnt_q == CNT_TERM) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Pulse only on the PRESS_WAIT->HELD transition; level tracks the pressed states.
  always_comb begin
    pulse_d = 1'b0;
    level_d = 1'b0;
    if ((state_q == PRESS_WAIT) && s2 && (cnt_q == CNT_TERM)) begin
      pulse_d = 1'b1;
    end
    if ((state_d == HELD) || (state_d == RELEASE_WAIT)) begin
      level_d = 1'b1;
    end
  end

  assign btn_pulse = pulse_q;
  assign btn_level = level_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: one debounce channel per button plus an optional
// one-hot pulse filter. Optional feature macro: BTN_ONEHOT_EN (keeps only the
// highest-priority pulse per cycle, center > top > bottom > left > right).
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NUM_BTN         = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_level
);

  logic [NUM_BTN-1:0] pulse_q;

  // Independent conditioning channel per button.
  for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .btn_raw  (btn_raw[i]),
      .btn_pulse(pulse_q[i]),
      .btn_level(btn_level[i])
    );
  end

`ifdef BTN_ONEHOT_EN
  // Lowest set bit wins; BTN_CENTER sits at bit 0 so it has top priority.
  assign btn_pulse = pulse_q & (~pulse_q + NUM_BTN'(1));
`else
  assign btn_pulse = pulse_q;
`endif

endmodule
